// File: rtl/vga_cell_timing_pkg.sv
// Shared VGA timing constants and tile-grid geometry.
// The renderer and sprite blocks import these so the whole screen pipeline agrees on one raster.
package vga_cell_timing_pkg;

  localparam int VGA_H_SYNC_CYCLES = 92;
  localparam int VGA_H_BACK_PORCH  = 50;
  localparam int VGA_H_DISPLAY     = 640;
  localparam int VGA_H_FRONT_PORCH = 18;
  localparam int VGA_V_SYNC_CYCLES = 2;
  localparam int VGA_V_BACK_PORCH  = 33;
  localparam int VGA_V_DISPLAY     = 480;
  localparam int VGA_V_FRONT_PORCH = 10;

  localparam int VGA_H_LINE  = VGA_H_SYNC_CYCLES + VGA_H_BACK_PORCH + VGA_H_DISPLAY + VGA_H_FRONT_PORCH;
  localparam int VGA_V_FRAME = VGA_V_SYNC_CYCLES + VGA_V_BACK_PORCH + VGA_V_DISPLAY + VGA_V_FRONT_PORCH;

  localparam int VGA_TILE_SHIFT = 5;
  localparam int VGA_GRID_W     = 20;
  localparam int VGA_GRID_H     = 15;

  localparam int VGA_CNT_W    = 10;
  localparam int VGA_CELL_X_W = 5;
  localparam int VGA_CELL_Y_W = 4;

  typedef struct packed {
    logic                    hsync_n;
    logic                    vsync_n;
    logic                    active;
    logic [VGA_CELL_X_W-1:0] cell_x;
    logic [VGA_CELL_Y_W-1:0] cell_y;
    logic                    frame_start;
  } vga_decode_t;

endpackage

// File: rtl/game_tick_div.sv
// Divides frame-start pulses down to a game tick; pause freezes the count.
// The tick is registered so it lines up with the registered frame-tick output.
module game_tick_div #(
  parameter int TICK_FRAMES = 8
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Frame_Tick,
  input  logic i_Pause,
  output logic o_Tick
);

  localparam logic [7:0] LAST = 8'(TICK_FRAMES - 1);

  logic [7:0] frame_cnt;

  // Pause is only looked at on the frame-start cycle, so mid-frame toggles are ignored.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      frame_cnt <= '0;
      o_Tick    <= 1'b0;
    end else begin
      o_Tick <= 1'b0;
      if (i_Frame_Tick && !i_Pause) begin
        if (frame_cnt == LAST) begin
          frame_cnt <= '0;
          o_Tick    <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_cell_timing.sv
// VGA raster generator with tile-cell decode and frame/game tick pulses.
// Every output is the registered decode of the previous (h,v), so all outputs stay aligned.
module vga_cell_timing
  import vga_cell_timing_pkg::*;
#(
  parameter int H_SYNC_CYCLES    = VGA_H_SYNC_CYCLES,
  parameter int H_BACK_PORCH     = VGA_H_BACK_PORCH,
  parameter int H_DISPLAY        = VGA_H_DISPLAY,
  parameter int H_FRONT_PORCH    = VGA_H_FRONT_PORCH,
  parameter int V_SYNC_CYCLES    = VGA_V_SYNC_CYCLES,
  parameter int V_BACK_PORCH     = VGA_V_BACK_PORCH,
  parameter int V_DISPLAY        = VGA_V_DISPLAY,
  parameter int V_FRONT_PORCH    = VGA_V_FRONT_PORCH,
  parameter int TILE_SHIFT       = VGA_TILE_SHIFT,
  parameter int GAME_TICK_FRAMES = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Pause,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic       o_Active,
  output logic [4:0] o_Cell_X,
  output logic [3:0] o_Cell_Y,
  output logic       o_Frame_Tick,
  output logic       o_Game_Tick
);

  localparam int H_LINE  = H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY + H_FRONT_PORCH;
  localparam int V_FRAME = V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY + V_FRONT_PORCH;

  localparam logic [VGA_CNT_W-1:0] H_LAST      = VGA_CNT_W'(H_LINE - 1);
  localparam logic [VGA_CNT_W-1:0] V_LAST      = VGA_CNT_W'(V_FRAME - 1);
  localparam logic [VGA_CNT_W-1:0] H_SYNC_END  = VGA_CNT_W'(H_SYNC_CYCLES);
  localparam logic [VGA_CNT_W-1:0] V_SYNC_END  = VGA_CNT_W'(V_SYNC_CYCLES);
  localparam logic [VGA_CNT_W-1:0] H_ACT_START = VGA_CNT_W'(H_SYNC_CYCLES + H_BACK_PORCH);
  localparam logic [VGA_CNT_W-1:0] H_ACT_END   = VGA_CNT_W'(H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY);
  localparam logic [VGA_CNT_W-1:0] V_ACT_START = VGA_CNT_W'(V_SYNC_CYCLES + V_BACK_PORCH);
  localparam logic [VGA_CNT_W-1:0] V_ACT_END   = VGA_CNT_W'(V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY);

  localparam vga_decode_t DEC_RESET = '{hsync_n: 1'b1, vsync_n: 1'b1, default: '0};

  logic [VGA_CNT_W-1:0] h_cnt, v_cnt;
  logic [VGA_CNT_W-1:0] h_off, v_off;
  logic                 h_act, v_act;
  vga_decode_t          dec_nxt, dec_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    h_act = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    v_act = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    h_off = h_cnt - H_ACT_START;
    v_off = v_cnt - V_ACT_START;

    dec_nxt             = DEC_RESET;
    dec_nxt.hsync_n     = !(h_cnt < H_SYNC_END);
    dec_nxt.vsync_n     = !(v_cnt < V_SYNC_END);
    dec_nxt.active      = h_act && v_act;
    dec_nxt.frame_start = (h_cnt == '0) && (v_cnt == '0);
    // Cell indices are forced to zero in blanking so downstream lookups see a stable address.
    if (h_act && v_act) begin
      dec_nxt.cell_x = VGA_CELL_X_W'(h_off >> TILE_SHIFT);
      dec_nxt.cell_y = VGA_CELL_Y_W'(v_off >> TILE_SHIFT);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) dec_q <= DEC_RESET;
    else          dec_q <= dec_nxt;
  end

  game_tick_div #(
    .TICK_FRAMES (GAME_TICK_FRAMES)
  ) u_game_tick_div (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Frame_Tick (dec_nxt.frame_start),
    .i_Pause      (i_Pause),
    .o_Tick       (o_Game_Tick)
  );

  assign o_VGA_HSync  = dec_q.hsync_n;
  assign o_VGA_VSync  = dec_q.vsync_n;
  assign o_Active     = dec_q.active;
  assign o_Cell_X     = dec_q.cell_x;
  assign o_Cell_Y     = dec_q.cell_y;
  assign o_Frame_Tick = dec_q.frame_start;

endmodule

// File: tb/tb_vga_cell_timing.sv
// Bench for vga_cell_timing: default-geometry raster checks plus a shrunken raster for tick/pause/reset.
// Expected game-tick frame numbers are queued up front and popped as the DUT pulses.
module tb_vga_cell_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s, pause_s;

  logic       d_hs, d_vs, d_act, d_ft, d_gt;
  logic [4:0] d_cx;
  logic [3:0] d_cy;
  logic       s_hs, s_vs, s_act, s_ft, s_gt;
  logic [4:0] s_cx;
  logic [3:0] s_cy;
  logic       o_hs, o_vs, o_act, o_ft, o_gt;
  logic [4:0] o_cx;
  logic [3:0] o_cy;

  int total = 0;
  int bad   = 0;
  int pos_d, pos_s, frame_no;
  int exp_q[$];
  int exp_f;

  // Default 800x525 raster
  vga_cell_timing dut_d (
    .i_Clk(clk), .i_Rst_L(rst_d), .i_Pause(1'b0),
    .o_VGA_HSync(d_hs), .o_VGA_VSync(d_vs), .o_Active(d_act),
    .o_Cell_X(d_cx), .o_Cell_Y(d_cy), .o_Frame_Tick(d_ft), .o_Game_Tick(d_gt)
  );

  // Small raster: line 25 clocks, frame 13 lines = 325 clocks, active h 7..22, v 4..11, 4 px tiles
  vga_cell_timing #(
    .H_SYNC_CYCLES(4), .H_BACK_PORCH(3), .H_DISPLAY(16), .H_FRONT_PORCH(2),
    .V_SYNC_CYCLES(2), .V_BACK_PORCH(2), .V_DISPLAY(8), .V_FRONT_PORCH(1),
    .TILE_SHIFT(2), .GAME_TICK_FRAMES(8)
  ) dut_s (
    .i_Clk(clk), .i_Rst_L(rst_s), .i_Pause(pause_s),
    .o_VGA_HSync(s_hs), .o_VGA_VSync(s_vs), .o_Active(s_act),
    .o_Cell_X(s_cx), .o_Cell_Y(s_cy), .o_Frame_Tick(s_ft), .o_Game_Tick(s_gt)
  );

  vga_cell_timing #(
    .H_SYNC_CYCLES(4), .H_BACK_PORCH(3), .H_DISPLAY(16), .H_FRONT_PORCH(2),
    .V_SYNC_CYCLES(2), .V_BACK_PORCH(2), .V_DISPLAY(8), .V_FRONT_PORCH(1),
    .TILE_SHIFT(2), .GAME_TICK_FRAMES(1)
  ) dut_1 (
    .i_Clk(clk), .i_Rst_L(rst_s), .i_Pause(1'b0),
    .o_VGA_HSync(o_hs), .o_VGA_VSync(o_vs), .o_Active(o_act),
    .o_Cell_X(o_cx), .o_Cell_Y(o_cy), .o_Frame_Tick(o_ft), .o_Game_Tick(o_gt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    pos_d++;
    pos_s++;
    if (rst_s) begin
      if (s_ft) frame_no++;
      if (s_gt) begin
        chk("game_tick_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_f = exp_q.pop_front();
          chk("game_tick_frame", frame_no, exp_f);
          chk("game_tick_with_frame", s_ft, 1);
        end
      end
      if (o_ft || o_gt) chk("gtf1_tick_eq_frame", o_gt, o_ft);
    end
  endtask

  task automatic goto_d(input int n);
    while (pos_d < n) step();
  endtask

  task automatic goto_s(input int n);
    while (pos_s < n) step();
  endtask

  task automatic chk_rst_s(input string tag);
    chk({tag, "_hs"}, s_hs, 1);
    chk({tag, "_vs"}, s_vs, 1);
    chk({tag, "_act"}, s_act, 0);
    chk({tag, "_cx"}, s_cx, 0);
    chk({tag, "_cy"}, s_cy, 0);
    chk({tag, "_ft"}, s_ft, 0);
    chk({tag, "_gt"}, s_gt, 0);
  endtask

  initial begin
    rst_d = 1'b0; rst_s = 1'b0; pause_s = 1'b0;
    pos_d = 0; pos_s = 0; frame_no = 0;
    repeat (3) step();
    chk_rst_s("rst_s");
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_act", d_act, 0);
    chk("rst_d_ft", d_ft, 0);
    chk("rst_d_gt", d_gt, 0);
    chk("rst_d_cell", {d_cx, d_cy}, 0);

    // Default raster
    @(negedge clk); rst_d = 1'b1; pos_d = -1;
    step();
    chk("d_first_ft", d_ft, 1);
    chk("d_first_hs", d_hs, 0);
    chk("d_first_vs", d_vs, 0);
    goto_d(91);    chk("d_hs_h91", d_hs, 0);
    goto_d(92);    chk("d_hs_h92", d_hs, 1);
    goto_d(800);   chk("d_hs_line1", d_hs, 0); chk("d_ft_line1", d_ft, 0);
    goto_d(1599);  chk("d_vs_v1", d_vs, 0);
    goto_d(1600);  chk("d_vs_v2", d_vs, 1);
    goto_d(28141); chk("d_act_141_35", d_act, 0);
    goto_d(28142); chk("d_act_142_35", d_act, 1); chk("d_cx_142", d_cx, 0); chk("d_cy_142", d_cy, 0);
    goto_d(28173); chk("d_act_173_35", d_act, 1); chk("d_cx_173", d_cx, 0); chk("d_cy_173", d_cy, 0);
    goto_d(28174); chk("d_cx_174_35", d_cx, 1);   chk("d_cy_174_35", d_cy, 0);
    goto_d(53774); chk("d_cx_174_67", d_cx, 1);   chk("d_cy_174_67", d_cy, 1);
    rst_d = 1'b0;

    // Small raster: timing, cells, game ticks on frames 8/16/24
    frame_no = 0;
    exp_q = '{8, 16, 24};
    @(negedge clk); rst_s = 1'b1; pos_s = -1;
    step();
    chk("s_first_ft", s_ft, 1);
    chk("s_first_hs", s_hs, 0);
    chk("s_first_vs", s_vs, 0);
    chk("s_first_act", s_act, 0);
    goto_s(3);   chk("s_hs_h3", s_hs, 0);
    goto_s(4);   chk("s_hs_h4", s_hs, 1);
    goto_s(24);  chk("s_hs_h24", s_hs, 1);
    goto_s(25);  chk("s_hs_line1", s_hs, 0);
    goto_s(49);  chk("s_vs_v1", s_vs, 0);
    goto_s(50);  chk("s_vs_v2", s_vs, 1);
    goto_s(106); chk("s_act_6_4", s_act, 0); chk("s_cell_6_4", {s_cx, s_cy}, 0);
    goto_s(107); chk("s_act_7_4", s_act, 1); chk("s_cell_7_4", {s_cx, s_cy}, 0);
    goto_s(110); chk("s_cx_10_4", s_cx, 0);  chk("s_cy_10_4", s_cy, 0);
    goto_s(211); chk("s_cx_11_8", s_cx, 1);  chk("s_cy_11_8", s_cy, 1);
    goto_s(297); chk("s_act_22_11", s_act, 1); chk("s_cx_22_11", s_cx, 3); chk("s_cy_22_11", s_cy, 1);
    goto_s(298); chk("s_act_23_11", s_act, 0); chk("s_cell_23_11", {s_cx, s_cy}, 0);
    goto_s(324); chk("s_ft_end", s_ft, 0);
    goto_s(325); chk("s_ft_period", s_ft, 1); chk("s_vs_frame2", s_vs, 0);
    goto_s(7480);
    chk("s_ticks_left_a", exp_q.size(), 0);
    chk("s_frames_a", frame_no, 24);

    // Asynchronous reset mid-frame at (12,6)
    goto_s(7962);
    chk("s_pre_rst_act", s_act, 1);
    chk("s_pre_rst_cx", s_cx, 1);
    #2 rst_s = 1'b0;
    #1 chk_rst_s("async_rst");
    step(); step();
    chk_rst_s("held_rst");
    frame_no = 0;
    exp_q = '{13, 21};
    @(negedge clk); rst_s = 1'b1; pos_s = -1;
    step();
    chk("s_restart_ft", s_ft, 1);
    chk("s_restart_hs", s_hs, 0);
    chk("s_restart_vs", s_vs, 0);

    // Pause over frame starts 5..9, then a mid-frame glitch after frame 14
    goto_s(1075); pause_s = 1'b1;
    goto_s(2700); pause_s = 1'b0;
    goto_s(4300); pause_s = 1'b1;
    goto_s(4310); pause_s = 1'b0;
    goto_s(6505);
    chk("s_ticks_left_c", exp_q.size(), 0);
    chk("s_frames_c", frame_no, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
